// File: rtl/ln_series_pkg.sv
// Shared types and constants for the ln(1+x) Taylor-series evaluator.
// Optional saturation of the result is enabled by defining LN_SERIES_SAT_EN.
package ln_series_pkg;

  localparam int Q31_W  = 32;
  localparam int ACC_W  = 35;
  localparam int ADDR_W = 4;
  localparam int LANES  = 4;

  localparam logic [ADDR_W-1:0] ADDR_IDLE = 4'hF;
  localparam logic [Q31_W-1:0]  Q31_MAX   = 32'h7FFF_FFFF;
  localparam logic [Q31_W-1:0]  Q31_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    POW2,
    POW3,
    POW4,
    ROUND0,
    POWHI,
    ROUND1,
    DONE
  } state_e;

  // Clamp the wide accumulator into the Q1.31 range.
  function automatic logic [Q31_W-1:0] sat_q31(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = {{(ACC_W-Q31_W){1'b0}}, Q31_MAX};
    lo = {{(ACC_W-Q31_W){1'b1}}, Q31_MIN};
    if (v > hi)      return Q31_MAX;
    else if (v < lo) return Q31_MIN;
    else             return v[Q31_W-1:0];
  endfunction

endpackage

// File: rtl/ln_series_evaluator_if.sv
// Four-lane coefficient LUT bus: the evaluator (master) drives addresses,
// the LUT (slave) returns Q1.31 coefficients combinationally.
interface ln_series_evaluator_if;
  import ln_series_pkg::*;

  logic [ADDR_W-1:0] addr1, addr2, addr3, addr4;
  logic [Q31_W-1:0]  coef1, coef2, coef3, coef4;

  modport master (
    output addr1, addr2, addr3, addr4,
    input  coef1, coef2, coef3, coef4
  );

  modport slave (
    input  addr1, addr2, addr3, addr4,
    output coef1, coef2, coef3, coef4
  );

endinterface

// File: rtl/q31_mul.sv
// Combinational signed Q1.31 multiply: (a*b) >>> 31, truncated, no rounding.
module q31_mul
  import ln_series_pkg::*;
(
  input  logic signed [Q31_W-1:0] a,
  input  logic signed [Q31_W-1:0] b,
  output logic signed [Q31_W-1:0] p
);

  logic signed [2*Q31_W-1:0] a_ext;
  logic signed [2*Q31_W-1:0] b_ext;

  assign a_ext = {{Q31_W{a[Q31_W-1]}}, a};
  assign b_ext = {{Q31_W{b[Q31_W-1]}}, b};
  assign p     = Q31_W'((a_ext * b_ext) >>> (Q31_W - 1));

endmodule

// File: rtl/ln_series_evaluator.sv
// ln(1+x) via the 8-term Taylor series, four multipliers shared across states.
// Define LN_SERIES_SAT_EN to saturate the result; otherwise it wraps.
module ln_series_evaluator
  import ln_series_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [Q31_W-1:0]   x_in,
  output logic               busy,
  output logic               done,
  output logic [Q31_W-1:0]   result,
  ln_series_evaluator_if.master lut
);

  state_e state, state_next;

  logic signed [Q31_W-1:0]  p [LANES];
  logic signed [Q31_W-1:0]  x4;
  logic signed [ACC_W-1:0]  acc, acc_sum;
  logic [Q31_W-1:0]         result_next;

  logic signed [Q31_W-1:0]  coef [LANES];
  logic signed [Q31_W-1:0]  ma [LANES], mb [LANES], mp [LANES];
  logic [ADDR_W-1:0]        addr [LANES];

  assign coef[0]   = lut.coef1;
  assign coef[1]   = lut.coef2;
  assign coef[2]   = lut.coef3;
  assign coef[3]   = lut.coef4;
  assign lut.addr1 = addr[0];
  assign lut.addr2 = addr[1];
  assign lut.addr3 = addr[2];
  assign lut.addr4 = addr[3];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block is assigned a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE:    if (start) state_next = POW2;
      POW2:    state_next = POW3;
      POW3:    state_next = POW4;
      POW4:    state_next = ROUND0;
      ROUND0:  state_next = POWHI;
      POWHI:   state_next = ROUND1;
      ROUND1:  state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand steering for the shared multipliers and the LUT addresses.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      addr[i] = ADDR_IDLE;
      ma[i]   = '0;
      mb[i]   = '0;
    end
    case (state)
      POW2: begin ma[0] = p[0]; mb[0] = p[0]; end
      POW3: begin ma[0] = p[1]; mb[0] = p[0]; end
      POW4: begin ma[0] = p[2]; mb[0] = p[0]; end
      ROUND0:
        for (int i = 0; i < LANES; i++) begin
          addr[i] = ADDR_W'(i);
          ma[i]   = coef[i];
          mb[i]   = p[i];
        end
      POWHI:
        for (int i = 0; i < LANES; i++) begin
          ma[i] = p[i];
          mb[i] = x4;
        end
      ROUND1:
        for (int i = 0; i < LANES; i++) begin
          addr[i] = ADDR_W'(i + LANES);
          ma[i]   = coef[i];
          mb[i]   = p[i];
        end
      default: ;
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_mul
    q31_mul u_mul (
      .a (ma[g]),
      .b (mb[g]),
      .p (mp[g])
    );
  end

  always_comb begin
    acc_sum = acc;
    for (int i = 0; i < LANES; i++)
      acc_sum = acc_sum + {{(ACC_W-Q31_W){mp[i][Q31_W-1]}}, mp[i]};
  end

`ifdef LN_SERIES_SAT_EN
  assign result_next = sat_q31(acc_sum);
`else
  assign result_next = acc_sum[Q31_W-1:0];
`endif

  // result is loaded on the ROUND1->DONE edge so it is valid alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the power array is only four words, so it is reset like any
      // other register rather than left uninitialised as a RAM would be.
      for (int i = 0; i < LANES; i++) p[i] <= '0;
      x4     <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            p[0] <= x_in;
            acc  <= '0;
          end
        POW2: p[1] <= mp[0];
        POW3: p[2] <= mp[0];
        POW4: begin
          p[3] <= mp[0];
          x4   <= mp[0];
        end
        ROUND0: acc <= acc_sum;
        POWHI:
          for (int i = 0; i < LANES; i++) p[i] <= mp[i];
        ROUND1: begin
          acc    <= acc_sum;
          result <= result_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ln_series_evaluator.sv
// Directed bench for ln_series_evaluator: cycle-exact handshake, LUT address
// sequencing, hand-computed series results, ignored starts and mid-run reset.
module tb_ln_series_evaluator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] x_in;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] last_result;

  ln_series_evaluator_if lut_bus ();

  ln_series_evaluator dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x_in   (x_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .lut    (lut_bus.master)
  );

  // Coefficient LUT: magnitudes truncated toward zero.
  function automatic logic [31:0] coef_of(input logic [3:0] a);
    case (a)
      4'd0:    return 32'h7FFF_FFFF;
      4'd1:    return 32'hC000_0000;
      4'd2:    return 32'h2AAA_AAAA;
      4'd3:    return 32'hE000_0000;
      4'd4:    return 32'h1999_9999;
      4'd5:    return 32'hEAAA_AAAB;
      4'd6:    return 32'h1249_2492;
      4'd7:    return 32'hF000_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  assign lut_bus.coef1 = coef_of(lut_bus.addr1);
  assign lut_bus.coef2 = coef_of(lut_bus.addr2);
  assign lut_bus.coef3 = coef_of(lut_bus.addr3);
  assign lut_bus.coef4 = coef_of(lut_bus.addr4);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addr_word();
    return {16'h0, lut_bus.addr1, lut_bus.addr2, lut_bus.addr3, lut_bus.addr4};
  endfunction

  // One full operation: cycle n (1..8) is the n-th cycle after acceptance.
  // With poke set, start is re-asserted in the POW3 and DONE cycles.
  task automatic run_op(input string name, input logic [31:0] x,
                        input logic [31:0] exp_res, input bit poke);
    logic [31:0] exp_addr;
    @(negedge clk);
    start = 1'b1;
    x_in  = x;
    @(posedge clk);
    #1;
    start = 1'b0;
    x_in  = 32'h1234_5678;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      exp_addr = (cyc == 4) ? 32'h0000_0123 :
                 (cyc == 6) ? 32'h0000_4567 : 32'h0000_FFFF;
      check($sformatf("%s c%0d busy", name, cyc), {31'h0, busy}, (cyc <= 7) ? 32'd1 : 32'd0);
      check($sformatf("%s c%0d done", name, cyc), {31'h0, done}, (cyc == 7) ? 32'd1 : 32'd0);
      check($sformatf("%s c%0d addr", name, cyc), addr_word(), exp_addr);
      check($sformatf("%s c%0d result", name, cyc), result, (cyc >= 7) ? exp_res : last_result);
      if (poke && (cyc == 2 || cyc == 7)) begin
        start = 1'b1;
        x_in  = 32'h4000_0000;
      end else begin
        start = 1'b0;
      end
    end
    last_result = exp_res;
  endtask

  logic [31:0] exp_neg_one;

  initial begin
`ifdef LN_SERIES_SAT_EN
    exp_neg_one = 32'h8000_0000;
`else
    // Exact sum is -5836553768 (about -2.718); low 32 bits of the accumulator.
    exp_neg_one = 32'hA41D_41D8;
`endif
    rst   = 1'b1;
    start = 1'b0;
    x_in  = 32'h0;
    last_result = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy",   {31'h0, busy}, 32'd0);
    check("reset done",   {31'h0, done}, 32'd0);
    check("reset result", result, 32'h0);
    check("reset addr",   addr_word(), 32'h0000_FFFF);
    rst = 1'b0;

    run_op("x0", 32'h0000_0000, 32'h0000_0000, 1'b0);
    // Terms: 1073741823 -268435456 +89478485 -33554432 +13421772 -5592406 +2396745 -1048576
    run_op("xp5", 32'h4000_0000, 32'h33E1_5F13, 1'b0);
    // Terms: -1073741824 -268435456 -89478486 -33554432 -13421773 -5592406 -2396746 -1048576
    run_op("xm5_poke", 32'hC000_0000, 32'hA753_F63D, 1'b1);
    run_op("xm1", 32'h8000_0001, exp_neg_one, 1'b0);

    // Reset while the FSM sits in ROUND0.
    @(negedge clk);
    start = 1'b1;
    x_in  = 32'h4000_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset round0 addr", addr_word(), 32'h0000_0123);
    rst = 1'b1;
    @(negedge clk);
    check("mid-reset busy",   {31'h0, busy}, 32'd0);
    check("mid-reset result", result, 32'h0);
    check("mid-reset addr",   addr_word(), 32'h0000_FFFF);
    check("mid-reset done",   {31'h0, done}, 32'd0);
    rst = 1'b0;
    last_result = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("post-reset idle %0d done", i), {31'h0, done}, 32'd0);
      check($sformatf("post-reset idle %0d busy", i), {31'h0, busy}, 32'd0);
    end

    run_op("after_reset", 32'hC000_0000, 32'hA753_F63D, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
